mips_status_monitor: RTL



---
 rtl/mips_status_monitor.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_status_monitor.sv
// Status-port consumer: counts R/I retirements and cycles, detects END/overflow/watchdog,
// then streams a 4-word summary (5 with MON_ADDR_CAPTURE_EN: captured PC) over valid/ready.
// Report outputs are registered and held while stalled; ready never feeds valid combinationally.
module mips_status_monitor #(
    parameter int CNT_W     = 32,
    parameter int MAX_CYCLE = 120000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_status,
    input  logic        i_status_valid,
    input  logic        i_clear,
`ifdef MON_ADDR_CAPTURE_EN
    input  logic [31:0] i_pc,
`endif
    output logic        o_rpt_valid,
    input  logic        i_rpt_ready,
    output logic [31:0] o_rpt_data,
    output logic [2:0]  o_rpt_idx,
    output logic        o_done,
    output logic [1:0]  o_term_code,
    output logic        o_late_status
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_REPORT,
        ST_DONE
    } state_t;

    localparam logic [1:0] TC_RUN     = 2'd0;
    localparam logic [1:0] TC_END     = 2'd1;
    localparam logic [1:0] TC_OVF     = 2'd2;
    localparam logic [1:0] TC_TIMEOUT = 2'd3;

`ifdef MON_ADDR_CAPTURE_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [31:0] zext(input logic [CNT_W-1:0] v);
        logic [31:0] w;
        w = '0;
        w[CNT_W-1:0] = v;
        return w;
    endfunction

    function automatic logic [31:0] word_at(
        input logic [2:0]       idx,
        input logic [CNT_W-1:0] r,
        input logic [CNT_W-1:0] i,
        input logic [CNT_W-1:0] cyc,
        input logic [1:0]       tc,
        input logic [31:0]      addr
    );
        logic [31:0] w;
        case (idx)
            3'd0:    w = zext(r);
            3'd1:    w = zext(i);
            3'd2:    w = zext(cyc);
            3'd3:    w = {30'b0, tc};
            3'd4:    w = addr;
            default: w = '0;
        endcase
        return w;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
    logic [CNT_W-1:0] i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [1:0]       term_code_q, term_code_d;
    logic             late_q, late_d;
    logic             rpt_valid_q, rpt_valid_d;
    logic [31:0]      rpt_data_q, rpt_data_d;
    logic [2:0]       rpt_idx_q, rpt_idx_d;
    logic [31:0]      addr_q, addr_d;

    logic [CNT_W-1:0] cyc_inc;
    logic             term_now;

    always_comb begin
        state_d     = state_q;
        r_cnt_d     = r_cnt_q;
        i_cnt_d     = i_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        term_code_d = term_code_q;
        late_d      = late_q;
        rpt_valid_d = rpt_valid_q;
        rpt_data_d  = rpt_data_q;
        rpt_idx_d   = rpt_idx_q;
        addr_d      = addr_q;
        cyc_inc     = sat_inc(cyc_cnt_q);
        term_now    = 1'b0;

        case (state_q)
            ST_RUN: begin
                cyc_cnt_d = cyc_inc;
                if (i_status_valid) begin
                    case (i_status)
                        2'd0: r_cnt_d = sat_inc(r_cnt_q);
                        2'd1: i_cnt_d = sat_inc(i_cnt_q);
                        2'd2: begin
                            term_code_d = TC_OVF;
                            term_now    = 1'b1;
                        end
                        default: begin
                            term_code_d = TC_END;
                            term_now    = 1'b1;
                        end
                    endcase
                end
                // A terminating status in the same cycle outranks the watchdog.
                if (!term_now && zext(cyc_inc) == 32'(MAX_CYCLE)) begin
                    term_code_d = TC_TIMEOUT;
                    term_now    = 1'b1;
                end
                if (term_now) begin
`ifdef MON_ADDR_CAPTURE_EN
                    addr_d = i_pc;
`endif
                    state_d     = ST_REPORT;
                    rpt_valid_d = 1'b1;
                    rpt_idx_d   = 3'd0;
                    rpt_data_d  = word_at(3'd0, r_cnt_d, i_cnt_d, cyc_cnt_d, term_code_d, addr_d);
                end
            end
            ST_REPORT: begin
                if (i_status_valid) begin
                    late_d = 1'b1;
                end
                if (i_rpt_ready) begin
                    if (rpt_idx_q == LAST_IDX) begin
                        state_d     = ST_DONE;
                        rpt_valid_d = 1'b0;
                        rpt_idx_d   = 3'd0;
                        rpt_data_d  = '0;
                    end else begin
                        rpt_idx_d  = rpt_idx_q + 3'd1;
                        rpt_data_d = word_at(rpt_idx_q + 3'd1, r_cnt_q, i_cnt_q, cyc_cnt_q,
                                             term_code_q, addr_q);
                    end
                end
            end
            ST_DONE: begin
                if (i_status_valid) begin
                    late_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (i_clear) begin
            state_d     = ST_RUN;
            r_cnt_d     = '0;
            i_cnt_d     = '0;
            cyc_cnt_d   = '0;
            term_code_d = TC_RUN;
            late_d      = 1'b0;
            rpt_valid_d = 1'b0;
            rpt_data_d  = '0;
            rpt_idx_d   = 3'd0;
            addr_d      = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            r_cnt_q     <= '0;
            i_cnt_q     <= '0;
            cyc_cnt_q   <= '0;
            term_code_q <= TC_RUN;
            late_q      <= 1'b0;
            rpt_valid_q <= 1'b0;
            rpt_data_q  <= '0;
            rpt_idx_q   <= 3'd0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            r_cnt_q     <= r_cnt_d;
            i_cnt_q     <= i_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
            term_code_q <= term_code_d;
            late_q      <= late_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_data_q  <= rpt_data_d;
            rpt_idx_q   <= rpt_idx_d;
            addr_q      <= addr_d;
        end
    end

    assign o_rpt_valid   = rpt_valid_q;
    assign o_rpt_data    = rpt_data_q;
    assign o_rpt_idx     = rpt_idx_q;
    assign o_done        = (state_q == ST_DONE);
    assign o_term_code   = term_code_q;
    assign o_late_status = late_q;

endmodule
